alu_result_stage: RTL and testbench

- Registered stage directly downstream of the execute-stage ALU datapath: the 16-bit adder/subtractor, the PADDSB sub-word unit, XOR, the shifters and RED.
- Accepts one ALU result per cycle on a valid/ready handshake and buffers up to two results in a 2-entry FIFO.
- Presents results in order to writeback.
- Owns the architectural N/V/Z flag register and commits flags only when a result is consumed downstream.

---
 rtl/alu_result_stage.sv | 116 +++++++++++
 tb/tb_alu_result_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered result stage behind the execute-stage ALU. Up to two ALU results
//   are buffered in a 2-entry FIFO and handed to writeback in order. The stage
//   also owns the architectural {N,V,Z} flags. Flags are committed only when an
//   entry is actually consumed by writeback, so that flushed or reset entries
//   never disturb them.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous discard of every buffered entry
//   in_valid/ready   upstream handshake; in_result/in_ovf/in_opcode/in_dst payload
//   out_valid/ready  writeback handshake; out_result/out_dst show the head entry
//   flags_nvz        architectural flags {N,V,Z}
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_result,
    input  logic         in_ovf,
    input  logic [3:0]   in_opcode,
    input  logic [3:0]   in_dst,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [3:0]   out_dst,
    output logic [2:0]   flags_nvz
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    typedef struct packed {
        logic [W-1:0] result;
        logic [3:0]   dst;
        logic [3:0]   opcode;
        logic         ovf;
    } entry_t;

    entry_t     mem [2];
    entry_t     head;
    logic       wr_ptr, rd_ptr;
    logic [1:0] count;
    logic       rdy_en;   // holds in_ready low during reset and for the first edge after it
    logic       push, pop;
    logic [2:0] flags_q, flags_d;

    assign in_ready   = rdy_en & (count < 2'(DEPTH));
    assign out_valid  = (count != 2'd0);
    assign head       = mem[rd_ptr];
    assign out_result = head.result;
    assign out_dst    = head.dst;
    assign flags_nvz  = flags_q;

    // A flush cycle swallows both handshakes so no flag commit can leak through.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        flags_d = flags_q;
        if (pop) begin
            case (head.opcode)
                OP_ADD, OP_SUB:
                    flags_d = {head.result[W-1], head.ovf, (head.result == '0)};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR:
                    flags_d[0] = (head.result == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en  <= 1'b0;
            count   <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            flags_q <= '0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            rdy_en  <= 1'b1;
            flags_q <= flags_d;
            if (flush) begin
                count  <= '0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= '{result: in_result, dst: in_dst,
                                     opcode: in_opcode, ovf: in_ovf};
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: ;
                endcase
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == 2'd2));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count == 2'd0));

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_RED = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4, OP_PADDSB = 4'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic        in_ovf = 1'b0;
    logic [3:0]  in_opcode = '0;
    logic [3:0]  in_dst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [3:0]  out_dst;
    logic [2:0]  flags_nvz;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  dst;
        logic [3:0]  op;
        logic        ovf;
    } exp_t;

    exp_t       q[$];
    logic [2:0] mflags = 3'b000;
    logic       mrdy = 1'b0;

    alu_result_stage #(.DEPTH(2), .W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_ovf(in_ovf), .in_opcode(in_opcode), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dst(out_dst), .flags_nvz(flags_nvz)
    );

    always #5 clk = ~clk;

    // Scoreboard: accepted inputs are queued, popped results compared in order,
    // and the flag model is advanced with each consumed entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mflags = 3'b000;
            mrdy   = 1'b0;
        end else begin
            automatic int  sz   = q.size();
            automatic logic exp_rdy = mrdy && (sz < 2);
            checks++;
            if (flags_nvz !== mflags) begin
                errors++;
                $display("FAIL mon_flags: got %b want %b at %0t", flags_nvz, mflags, $time);
            end
            checks++;
            if (out_valid !== (sz != 0)) begin
                errors++;
                $display("FAIL mon_out_valid: got %b want %b at %0t", out_valid, sz != 0, $time);
            end
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL mon_in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
            end
            if (sz != 0 && out_ready && !flush) begin
                automatic exp_t e = q.pop_front();
                checks++;
                if (out_result !== e.res || out_dst !== e.dst) begin
                    errors++;
                    $display("FAIL mon_pop: got %h/%0d want %h/%0d at %0t",
                             out_result, out_dst, e.res, e.dst, $time);
                end
                case (e.op)
                    OP_ADD, OP_SUB: mflags = {e.res[15], e.ovf, e.res == 16'h0};
                    4'd2, 4'd4, 4'd5, 4'd6: mflags[0] = (e.res == 16'h0);
                    default: ;
                endcase
            end
            if (flush) q.delete();
            else if (in_valid && exp_rdy)
                q.push_back('{res: in_result, dst: in_dst, op: in_opcode, ovf: in_ovf});
            mrdy = 1'b1;
        end
    end

    // Drive one result and hold it until accepted; returns at posedge+1 of the capturing edge.
    task automatic push_one(input logic [3:0] op, input logic [15:0] res,
                            input logic ovf, input logic [3:0] dst);
        logic acc;
        int   n;
        in_valid = 1'b1; in_opcode = op; in_result = res; in_ovf = ovf; in_dst = dst;
        n = 0;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 20);
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout: result %h not accepted", res);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
        end
        checks++;
        if (out_result !== 16'h0 || out_dst !== 4'h0 || flags_nvz !== 3'b000) begin
            errors++;
            $display("FAIL reset_vals: result=%h dst=%0d flags=%b want 0", out_result, out_dst, flags_nvz);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: in_ready=%b want 0", in_ready);
        end
        wait_cycles(1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_single_pass;
        out_ready = 1'b1;
        push_one(OP_PADDSB, 16'h2395, 1'b0, 4'd3);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'h2395 || out_dst !== 4'd3) begin
            errors++;
            $display("FAIL single_pass: v=%b r=%h d=%0d want 1/2395/3", out_valid, out_result, out_dst);
        end
        wait_cycles(2);
        checks++;
        if (flags_nvz !== 3'b000) begin
            errors++;
            $display("FAIL single_flags: got %b want 000", flags_nvz);
        end
    endtask

    task automatic test_add_flags;
        out_ready = 1'b1;
        push_one(OP_ADD, 16'h8000, 1'b1, 4'd1);
        wait_cycles(2);
        checks++;
        if (flags_nvz !== 3'b110) begin
            errors++;
            $display("FAIL add_flags: got %b want 110", flags_nvz);
        end
        push_one(OP_SUB, 16'h0000, 1'b0, 4'd2);
        wait_cycles(2);
        checks++;
        if (flags_nvz !== 3'b001) begin
            errors++;
            $display("FAIL sub_flags: got %b want 001", flags_nvz);
        end
    endtask

    task automatic test_zonly;
        out_ready = 1'b1;
        push_one(OP_ADD, 16'h8000, 1'b1, 4'd1);
        wait_cycles(2);
        push_one(OP_XOR, 16'h0000, 1'b0, 4'd5);
        wait_cycles(2);
        checks++;
        if (flags_nvz !== 3'b111) begin
            errors++;
            $display("FAIL xor_flags: got %b want 111", flags_nvz);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        push_one(OP_RED, 16'h0001, 1'b0, 4'd6);
        push_one(OP_RED, 16'h0002, 1'b0, 4'd7);
        checks++;
        if (in_ready !== 1'b0 || out_result !== 16'h0001) begin
            errors++;
            $display("FAIL full: in_ready=%b head=%h want 0/0001", in_ready, out_result);
        end
        in_valid = 1'b1; in_opcode = OP_RED; in_result = 16'h0003; in_dst = 4'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_result !== 16'h0001) begin
                errors++;
                $display("FAIL full_hold: in_ready=%b head=%h want 0/0001", in_ready, out_result);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_result !== 16'h0001) begin
            errors++;
            $display("FAIL drain0: got %h want 0001", out_result);
        end
        @(negedge clk);
        checks++;
        if (out_result !== 16'h0002 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain1: got %h v=%b want 0002/1", out_result, out_valid);
        end
        wait_cycles(2);
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_one(OP_SLL, 16'h0010 + 16'(k), 1'b0, 4'(k));
            checks++;
            if (out_valid !== 1'b1 || out_result !== 16'h0010 + 16'(k) || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: v=%b r=%h rdy=%b want 1/%h/1", k, out_valid, out_result,
                         in_ready, 16'h0010 + 16'(k));
            end
        end
        wait_cycles(2);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush_reset;
        out_ready = 1'b1;
        push_one(OP_SUB, 16'h0000, 1'b0, 4'd1);
        wait_cycles(2);
        out_ready = 1'b0;
        push_one(OP_ADD, 16'h8000, 1'b1, 4'd2);
        push_one(OP_ADD, 16'h7fff, 1'b0, 4'd3);
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_opcode = OP_ADD; in_result = 16'h8000; in_ovf = 1'b1;
        wait_cycles(1);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || flags_nvz !== 3'b001) begin
            errors++;
            $display("FAIL flush: v=%b flags=%b want 0/001", out_valid, flags_nvz);
        end
        wait_cycles(1);
        checks++;
        if (flags_nvz !== 3'b001 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: flags=%b rdy=%b want 001/1", flags_nvz, in_ready);
        end
        out_ready = 1'b0;
        push_one(OP_XOR, 16'h0005, 1'b0, 4'd4);
        push_one(OP_XOR, 16'h0006, 1'b0, 4'd5);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || flags_nvz !== 3'b000 || in_ready !== 1'b0 || out_result !== 16'h0) begin
            errors++;
            $display("FAIL midreset: v=%b flags=%b rdy=%b r=%h want 0/000/0/0",
                     out_valid, flags_nvz, in_ready, out_result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cycles(1);
        out_ready = 1'b1;
        push_one(OP_ADD, 16'h0000, 1'b0, 4'd9);
        checks++;
        if (out_result !== 16'h0000 || out_dst !== 4'd9 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: r=%h d=%0d v=%b want 0000/9/1", out_result, out_dst, out_valid);
        end
        wait_cycles(2);
        checks++;
        if (flags_nvz !== 3'b001) begin
            errors++;
            $display("FAIL post_reset_flags: got %b want 001", flags_nvz);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_add_flags();
        test_zonly();
        test_backpressure();
        test_back_to_back();
        test_flush_reset();
        for (int i = 0; i < 20 && q.size() != 0; i++) wait_cycles(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
